uart_rx_ctrl: RTL and testbench

Receive sequencer for the UART path. It consumes the debounced line level from the RX input filter and the oversampling strobe that drives it. It frames start, data, optional parity and stop bits, then delivers each byte through a one-entry output buffer with a valid/ready handshake. Framing, overrun and parity faults are reported as status.

---
 rtl/uart_rx_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: frames start/data/[parity]/stop from oversampling ticks and hands bytes out
// through a one-entry valid/ready buffer. Define UART_RX_PARITY_EN to compile in the parity bit.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 samp_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 perr,
  output logic                 ferr,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_e;

  function automatic logic parity_err(input logic [DATA_BITS-1:0] bits, input logic pbit);
    return (((^bits) ^ pbit) != ODD);
  endfunction

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc_s;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 done_s;
  logic                 full_tick_s;

  // Frame sequencing and output-buffer next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    data_d      = data_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    ferr_d      = 1'b0;
    overrun_d   = 1'b0;
    done_s      = 1'b0;
    cnt_inc_s   = (cnt_q == FULL_M1) ? {CW{1'b0}} : cnt_q + CW'(1);
    full_tick_s = samp_clk && (cnt_q == FULL_M1);

    case (state_q)
      S_IDLE: begin
        if (samp_clk && !rx) begin
          state_d = S_START;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (samp_clk && (cnt_q == HALF_M1)) begin
          cnt_d   = {CW{1'b0}};
          bit_d   = {BW{1'b0}};
          state_d = rx ? S_IDLE : S_DATA;
        end else if (samp_clk) begin
          cnt_d = cnt_inc_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DATA: begin
        if (full_tick_s) begin
          cnt_d   = {CW{1'b0}};
          shift_d = {rx, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            bit_d = {BW{1'b0}};
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else if (samp_clk) begin
          cnt_d = cnt_inc_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (full_tick_s) begin
          cnt_d     = {CW{1'b0}};
          par_err_d = parity_err(shift_q, rx);
          state_d   = S_STOP;
        end else if (samp_clk) begin
          cnt_d = cnt_inc_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
`endif
      S_STOP: begin
        if (full_tick_s) begin
          cnt_d = {CW{1'b0}};
          if (rx) begin
            done_s  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else if (samp_clk) begin
          cnt_d = cnt_inc_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_BREAK: begin
        if (samp_clk && rx) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
        bit_d   = {BW{1'b0}};
      end
    endcase

    // A completing byte may replace a held one only if that one is consumed this same edge.
    if (done_s) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
        perr_d  = par_err_q;
`else
        perr_d  = 1'b0;
`endif
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      bit_q     <= {BW{1'b0}};
      shift_q   <= {DATA_BITS{1'b0}};
      par_err_q <= 1'b0;
      data_q    <= {DATA_BITS{1'b0}};
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign perr    = perr_q;
  assign ferr    = ferr_q;
  assign overrun = overrun_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus pushes expected bytes/status pulses, a negedge monitor pops them.
module tb_uart_rx_ctrl;

  localparam int OS   = 16;
  localparam int DB   = 8;
  localparam int TICK = 4;
  localparam int BIT  = OS * TICK;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int STOP_CYC  = (OS / 2 + (DB + 1 + P) * OS) * TICK;
  localparam int START_CYC = (OS / 2) * TICK;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic       clk, rst_n, samp_clk, rx, ready;
  logic [7:0] data;
  logic       valid, perr, ferr, overrun, busy;

  exp_t exp_byte_q[$];
  int   exp_ferr_q[$];
  int   exp_ovr_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_cyc = 0;
  int   valid_cyc = 0;
  int   samp_cnt = 0;
  logic par_flip = 1'b0;

  uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .samp_clk(samp_clk), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .perr(perr), .ferr(ferr), .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    samp_clk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      samp_cnt = (samp_cnt + 1) % TICK;
      samp_clk = (samp_cnt == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and status pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cyc++;
      if (valid) valid_cyc++;
      if (valid && ready) begin
        if (exp_byte_q.size() == 0) begin
          check("unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_byte_q.pop_front();
          check("byte_data", {24'd0, data}, {24'd0, e.d});
          check("byte_perr", {31'd0, perr}, {31'd0, e.p});
        end
      end
      if (ferr) begin
        if (exp_ferr_q.size() == 0) check("unexpected_ferr", 32'd1, 32'd0);
        else check("ferr_pulse", 32'd1, 32'(exp_ferr_q.pop_front()));
      end
      if (overrun) begin
        if (exp_ovr_q.size() == 0) check("unexpected_overrun", 32'd1, 32'd0);
        else check("overrun_pulse", 32'd1, 32'(exp_ovr_q.pop_front()));
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_body(input logic [7:0] b);
    rx = 1'b0;
    hold(BIT);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      hold(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    hold(BIT);
`endif
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_body(b);
    rx = 1'b1;
    hold(BIT);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic p);
    exp_t e;
    e.d = d;
    e.p = p;
    exp_byte_q.push_back(e);
  endtask

  // Raise ready for exactly the stop-sample edge of the frame that is starting.
  task automatic ready_on_stop();
    int n;
    n = 0;
    while (!busy && n < 4 * BIT) begin
      @(negedge clk);
      n++;
    end
    check("busy_rise_seen", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    hold(STOP_CYC - 2);
    ready = 1'b1;
    hold(1);
    ready = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    hold(3);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_status", {29'd0, perr, ferr, overrun}, 32'd0);
    rst_n = 1'b1;
    hold(BIT);

    // 0xA5 with ready high: single-cycle valid, busy spans start detect to stop sample
    busy_cyc = 0;
    valid_cyc = 0;
    push_byte(8'hA5, 1'b0);
    send_frame(8'hA5);
    check("a5_busy_cycles", 32'(busy_cyc), 32'(STOP_CYC));
    check("a5_valid_cycles", 32'(valid_cyc), 32'd1);

    // 3-tick low glitch is rejected at the mid-start check
    busy_cyc = 0;
    rx = 1'b0;
    hold(3 * TICK);
    rx = 1'b1;
    hold(BIT);
    check("glitch_busy_cycles", 32'(busy_cyc), 32'(START_CYC));
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    check("glitch_valid_low", {31'd0, valid}, 32'd0);

    // 0x3C with stop held low two bit periods, then 0x81
    exp_ferr_q.push_back(1);
    send_body(8'h3C);
    rx = 1'b0;
    hold(2 * BIT);
    check("break_busy_high", {31'd0, busy}, 32'd1);
    check("break_valid_low", {31'd0, valid}, 32'd0);
    rx = 1'b1;
    hold(BIT);
    check("break_exit_busy", {31'd0, busy}, 32'd0);
    push_byte(8'h81, 1'b0);
    send_frame(8'h81);

    // Reset mid-frame aborts silently, then 0x5A is received
    rx = 1'b0;
    hold(BIT);
    rx = 1'b1;
    hold(BIT + BIT / 2);
    rst_n = 1'b0;
    hold(2);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    rst_n = 1'b1;
    hold(2 * BIT);
    push_byte(8'h5A, 1'b0);
    send_frame(8'h5A);

    // Overrun: 0x11 held, 0x22 dropped
    ready = 1'b0;
    push_byte(8'h11, 1'b0);
    send_frame(8'h11);
    exp_ovr_q.push_back(1);
    send_frame(8'h22);
    check("ovr_valid_held", {31'd0, valid}, 32'd1);
    check("ovr_data_held", {24'd0, data}, 32'h11);
    ready = 1'b1;
    hold(1);
    ready = 1'b0;
    check("ovr_valid_cleared", {31'd0, valid}, 32'd0);
    check("ovr_data_kept", {24'd0, data}, 32'h11);

    // Consume on the stop-sample edge of 0x55 while 0x11 is held: no overrun
    push_byte(8'h11, 1'b0);
    send_frame(8'h11);
    push_byte(8'h55, 1'b0);
    fork
      send_frame(8'h55);
      ready_on_stop();
    join
    check("same_cycle_valid", {31'd0, valid}, 32'd1);
    check("same_cycle_data", {24'd0, data}, 32'h55);
    ready = 1'b1;
    hold(2);

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
    push_byte(8'h07, 1'b0);
    send_frame(8'h07);
    par_flip = 1'b1;
    ready = 1'b0;
    push_byte(8'h07, 1'b1);
    send_frame(8'h07);
    check("par_valid", {31'd0, valid}, 32'd1);
    check("par_perr", {31'd0, perr}, 32'd1);
    check("par_data", {24'd0, data}, 32'h07);
    ready = 1'b1;
    hold(2);
    par_flip = 1'b0;
`endif

    hold(BIT);
    check("pending_bytes", 32'(exp_byte_q.size()), 32'd0);
    check("pending_ferr", 32'(exp_ferr_q.size()), 32'd0);
    check("pending_overrun", 32'(exp_ovr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
